pll_cfg_ctrl: RTL and testbench

Configuration and lock sequencer that drives a pll instance's divider and reset inputs and consumes its lock output. It accepts divider-change requests over a valid/ready handshake, holds the PLL in reset while new dividers settle, then waits for a qualified lock with a timeout. It runs in an always-on clock domain (typically the PLL reference clock) and reports lock status, completion, timeout and lock-loss to the system.

---
 rtl/pll_cfg_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_pll_cfg_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: divider-change and lock-qualification sequencer for a PLL.
// Build option: define PLL_CFG_CTRL_RELOCK_EN for automatic relock with up to 3 retries.
module pll_cfg_ctrl #(
   parameter int REF_DIV_WIDTH = 4,
   parameter int FB_DIV_WIDTH  = 8,
   parameter int DEF_REFDIV    = 1,
   parameter int DEF_FBDIV     = 2,
   parameter int RST_CYCLES    = 4,
   parameter int LOCK_STABLE   = 8,
   parameter int LOCK_TIMEOUT  = 64
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [REF_DIV_WIDTH-1:0] req_refdiv_i,
   input  logic [FB_DIV_WIDTH-1:0]  req_fbdiv_i,
   output logic [REF_DIV_WIDTH-1:0] refdiv_o,
   output logic [FB_DIV_WIDTH-1:0]  fbdiv_o,
   output logic                     pll_arst_no,
   input  logic                     pll_locked_i,
   output logic                     locked_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     lost_o
);

   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_IDLE = 2'd2;

   localparam int MAX_CNT = (RST_CYCLES > LOCK_STABLE) ?
                            ((RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT) :
                            ((LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT);
   localparam int CW = $clog2(MAX_CNT + 1);

   logic                     lk_meta_r, lk_sync_r;
   logic [1:0]               state_r, state_nx_s;
   logic [CW-1:0]            hcnt_r, hcnt_nx_s;
   logic [CW-1:0]            tcnt_r, tcnt_nx_s;
   logic [CW-1:0]            scnt_r, scnt_nx_s;
   logic [CW-1:0]            tcnt_inc_s, scnt_inc_s;
   logic [REF_DIV_WIDTH-1:0] refdiv_r, refdiv_nx_s;
   logic [FB_DIV_WIDTH-1:0]  fbdiv_r, fbdiv_nx_s;
   logic                     arst_n_r, arst_n_nx_s;
   logic                     locked_r, locked_nx_s;
   logic                     busy_r, busy_nx_s;
   logic                     done_r, done_nx_s;
   logic                     err_r, err_nx_s;
   logic                     lost_r, lost_nx_s;
   logic                     ready_r, ready_nx_s;
`ifdef PLL_CFG_CTRL_RELOCK_EN
   logic [1:0]               retry_r, retry_nx_s;
`endif

   assign tcnt_inc_s = tcnt_r + CW'(1);
   assign scnt_inc_s = scnt_r + CW'(1);

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         lk_meta_r <= 1'b0;
         lk_sync_r <= 1'b0;
      end else begin
         lk_meta_r <= pll_locked_i;
         lk_sync_r <= lk_meta_r;
      end
   end

   // Next-state and next-output decode for the HOLD / WAIT / IDLE sequencer.
   always_comb begin
      state_nx_s  = state_r;
      hcnt_nx_s   = hcnt_r;
      tcnt_nx_s   = tcnt_r;
      scnt_nx_s   = scnt_r;
      refdiv_nx_s = refdiv_r;
      fbdiv_nx_s  = fbdiv_r;
      arst_n_nx_s = arst_n_r;
      locked_nx_s = locked_r;
      busy_nx_s   = busy_r;
      done_nx_s   = 1'b0;
      err_nx_s    = err_r;
      lost_nx_s   = lost_r;
      ready_nx_s  = ready_r;
`ifdef PLL_CFG_CTRL_RELOCK_EN
      retry_nx_s  = retry_r;
`endif
      case (state_r)
         ST_HOLD: begin
            if (hcnt_r == CW'(RST_CYCLES - 1)) begin
               arst_n_nx_s = 1'b1;
               hcnt_nx_s   = {CW{1'b0}};
               tcnt_nx_s   = {CW{1'b0}};
               scnt_nx_s   = {CW{1'b0}};
               state_nx_s  = ST_WAIT;
            end else begin
               hcnt_nx_s   = hcnt_r + CW'(1);
            end
         end
         ST_WAIT: begin
            tcnt_nx_s = tcnt_inc_s;
            if (lk_sync_r) begin
               scnt_nx_s = scnt_inc_s;
            end else begin
               scnt_nx_s = {CW{1'b0}};
            end
            // Lock qualification takes priority over a coincident timeout.
            if (lk_sync_r && (scnt_inc_s == CW'(LOCK_STABLE))) begin
               locked_nx_s = 1'b1;
               done_nx_s   = 1'b1;
               busy_nx_s   = 1'b0;
               ready_nx_s  = 1'b1;
               state_nx_s  = ST_IDLE;
`ifdef PLL_CFG_CTRL_RELOCK_EN
               retry_nx_s  = 2'd0;
`endif
            end else if (tcnt_inc_s == CW'(LOCK_TIMEOUT)) begin
`ifdef PLL_CFG_CTRL_RELOCK_EN
               if (retry_r != 2'd3) begin
                  retry_nx_s  = retry_r + 2'd1;
                  arst_n_nx_s = 1'b0;
                  hcnt_nx_s   = {CW{1'b0}};
                  state_nx_s  = ST_HOLD;
               end else begin
                  err_nx_s    = 1'b1;
                  locked_nx_s = 1'b0;
                  busy_nx_s   = 1'b0;
                  ready_nx_s  = 1'b1;
                  state_nx_s  = ST_IDLE;
               end
`else
               err_nx_s    = 1'b1;
               locked_nx_s = 1'b0;
               busy_nx_s   = 1'b0;
               ready_nx_s  = 1'b1;
               state_nx_s  = ST_IDLE;
`endif
            end else begin
               state_nx_s = ST_WAIT;
            end
         end
         ST_IDLE: begin
            // An accepted request clears any lock loss seen in the same cycle.
            if (req_valid_i && ready_r) begin
               refdiv_nx_s = req_refdiv_i;
               fbdiv_nx_s  = req_fbdiv_i;
               err_nx_s    = 1'b0;
               lost_nx_s   = 1'b0;
               locked_nx_s = 1'b0;
               ready_nx_s  = 1'b0;
               busy_nx_s   = 1'b1;
               arst_n_nx_s = 1'b0;
               hcnt_nx_s   = {CW{1'b0}};
               state_nx_s  = ST_HOLD;
`ifdef PLL_CFG_CTRL_RELOCK_EN
               retry_nx_s  = 2'd0;
`endif
            end else if (locked_r && !lk_sync_r) begin
               locked_nx_s = 1'b0;
               lost_nx_s   = 1'b1;
`ifdef PLL_CFG_CTRL_RELOCK_EN
               ready_nx_s  = 1'b0;
               busy_nx_s   = 1'b1;
               arst_n_nx_s = 1'b0;
               hcnt_nx_s   = {CW{1'b0}};
               retry_nx_s  = 2'd0;
               state_nx_s  = ST_HOLD;
`endif
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s  = ST_HOLD;
            hcnt_nx_s   = {CW{1'b0}};
            arst_n_nx_s = 1'b0;
            locked_nx_s = 1'b0;
            busy_nx_s   = 1'b1;
            ready_nx_s  = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_r  <= ST_HOLD;
         hcnt_r   <= {CW{1'b0}};
         tcnt_r   <= {CW{1'b0}};
         scnt_r   <= {CW{1'b0}};
         refdiv_r <= REF_DIV_WIDTH'(DEF_REFDIV);
         fbdiv_r  <= FB_DIV_WIDTH'(DEF_FBDIV);
         arst_n_r <= 1'b0;
         locked_r <= 1'b0;
         busy_r   <= 1'b1;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
         lost_r   <= 1'b0;
         ready_r  <= 1'b0;
`ifdef PLL_CFG_CTRL_RELOCK_EN
         retry_r  <= 2'd0;
`endif
      end else begin
         state_r  <= state_nx_s;
         hcnt_r   <= hcnt_nx_s;
         tcnt_r   <= tcnt_nx_s;
         scnt_r   <= scnt_nx_s;
         refdiv_r <= refdiv_nx_s;
         fbdiv_r  <= fbdiv_nx_s;
         arst_n_r <= arst_n_nx_s;
         locked_r <= locked_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
         err_r    <= err_nx_s;
         lost_r   <= lost_nx_s;
         ready_r  <= ready_nx_s;
`ifdef PLL_CFG_CTRL_RELOCK_EN
         retry_r  <= retry_nx_s;
`endif
      end
   end

   assign req_ready_o = ready_r;
   assign refdiv_o    = refdiv_r;
   assign fbdiv_o     = fbdiv_r;
   assign pll_arst_no = arst_n_r;
   assign locked_o    = locked_r;
   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign err_o       = err_r;
   assign lost_o      = lost_r;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl: scoreboard bench for pll_cfg_ctrl; each started sequence pushes its
// expected completion (kind, latency, dividers), popped when done_o or a new err_o appears.
module tb_pll_cfg_ctrl;

   localparam int RST_CYCLES   = 4;
   localparam int LOCK_STABLE  = 8;
   localparam int LOCK_TIMEOUT = 64;

   typedef struct {
      int         start;
      int         lat;
      bit         is_lock;
      logic [3:0] rd;
      logic [7:0] fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       srst_i = 1'b0;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic [3:0] req_refdiv_i = 4'd0;
   logic [7:0] req_fbdiv_i = 8'd0;
   logic [3:0] refdiv_o;
   logic [7:0] fbdiv_o;
   logic       pll_arst_no;
   logic       pll_locked_i = 1'b0;
   logic       locked_o, busy_o, done_o, err_o, lost_o;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;
   bit   err_prev = 1'b0;
   bit   done_chk = 1'b0;

   // lock waveform, indexed by edges since the current sequence start
   int   seq_start = 0;
   int   pat_rise = 0;
   int   pat_fall = 1 << 30;
   bit   pat_glitch = 1'b0;

   pll_cfg_ctrl #(
      .REF_DIV_WIDTH(4), .FB_DIV_WIDTH(8), .DEF_REFDIV(1), .DEF_FBDIV(2),
      .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
   ) dut (
      .clk_i(clk), .srst_i(srst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_refdiv_i(req_refdiv_i), .req_fbdiv_i(req_fbdiv_i), .refdiv_o(refdiv_o),
      .fbdiv_o(fbdiv_o), .pll_arst_no(pll_arst_no), .pll_locked_i(pll_locked_i),
      .locked_o(locked_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .lost_o(lost_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit pat_level(input int j);
      return (j >= pat_rise) && !(pat_glitch && (j == pat_rise + 5)) && (j < pat_fall);
   endfunction

   // Latency from the start edge to done/err, given the lock waveform.
   function automatic int exp_lat(input int rise, input bit glitch, output bit is_lock);
      int zl, ll;
      zl = glitch ? rise + 5 : rise - 1;
      ll = (((zl + 2) > RST_CYCLES) ? zl + 2 : RST_CYCLES) + LOCK_STABLE;
      is_lock = (ll <= RST_CYCLES + LOCK_TIMEOUT);
      return is_lock ? ll : RST_CYCLES + LOCK_TIMEOUT;
   endfunction

   // Called at a negedge: next posedge starts a sequence (reset or request acceptance).
   task automatic start_seq(input bit by_reset, input logic [3:0] rd, input logic [7:0] fd,
                            input int rise, input bit glitch);
      exp_t e;
      bit   lk;
      e.start = cyc + 1;
      e.lat = exp_lat(rise, glitch, lk);
      e.is_lock = lk;
      e.rd = rd;
      e.fd = fd;
      seq_start = cyc + 1;
      pat_rise = rise;
      pat_glitch = glitch;
      pat_fall = 1 << 30;
      if (by_reset) begin
         sb.delete();
         srst_i = 1'b1;
      end else begin
         check_val("ready_before_req", req_ready_o, 1);
         req_valid_i = 1'b1;
         req_refdiv_i = rd;
         req_fbdiv_i = fd;
      end
      sb.push_back(e);
      @(negedge clk);
      srst_i = 1'b0;
      req_valid_i = 1'b0;
      check_val("start_refdiv", refdiv_o, rd);
      check_val("start_fbdiv", fbdiv_o, fd);
      check_val("start_arst", pll_arst_no, 0);
      check_val("start_locked", locked_o, 0);
      check_val("start_busy", busy_o, 1);
      check_val("start_ready", req_ready_o, 0);
      check_val("start_done", done_o, 0);
      check_val("start_err", err_o, 0);
      check_val("start_lost", lost_o, 0);
      for (int k = 1; k <= RST_CYCLES; k++) begin
         @(negedge clk);
         check_val("hold_arst", pll_arst_no, (k >= RST_CYCLES) ? 1 : 0);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(req_ready_o === 1'b1 && busy_o === 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_reached", (n < budget) ? 1 : 0, 1);
   endtask

   // Lock input driver, updated just after each negedge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         pll_locked_i = pat_level(cyc - seq_start + 1);
      end
   end

   // Scoreboard monitor: pops an expectation on each completion event.
   initial begin
      forever begin
         @(negedge clk);
         if (done_chk) begin
            check_val("done_pulse", done_o, 0);
            done_chk = 1'b0;
         end
         if (done_o === 1'b1 || (err_o === 1'b1 && err_prev !== 1'b1)) begin
            if (sb.size() == 0) begin
               check_val("sb_unexpected", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check_val("sb_kind_lock", done_o, mon_e.is_lock);
               check_val("sb_err", err_o, !mon_e.is_lock);
               check_val("sb_latency", cyc - mon_e.start, mon_e.lat);
               check_val("sb_refdiv", refdiv_o, mon_e.rd);
               check_val("sb_fbdiv", fbdiv_o, mon_e.fd);
               check_val("sb_locked", locked_o, mon_e.is_lock);
               check_val("sb_ready", req_ready_o, 1);
               check_val("sb_busy", busy_o, 0);
               check_val("sb_arst", pll_arst_no, 1);
               done_chk = 1'b1;
            end
         end
         err_prev = err_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk);
      // reset with lock steady high
      start_seq(1'b1, 4'd1, 8'd2, 0, 1'b0);
      wait_idle(100);
      // request with lock dropping during PLL reset, then a request held while busy
      start_seq(1'b0, 4'd2, 8'd4, 10, 1'b0);
      req_valid_i = 1'b1;
      req_refdiv_i = 4'd5;
      req_fbdiv_i = 8'd6;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_val("held_ready", req_ready_o, 0);
         check_val("held_refdiv", refdiv_o, 4'd2);
      end
      wait_idle(100);
      start_seq(1'b0, 4'd5, 8'd6, 3, 1'b0);
      wait_idle(100);
      // lock glitch restarts the stability count
      start_seq(1'b0, 4'd7, 8'd9, 6, 1'b1);
      wait_idle(100);
      // lock loss while idle
      pat_fall = cyc - seq_start + 1;
      @(negedge clk);
      check_val("loss_e1_lost", lost_o, 0);
      @(negedge clk);
      check_val("loss_e2_lost", lost_o, 0);
      check_val("loss_e2_locked", locked_o, 1);
      @(negedge clk);
      check_val("loss_e3_lost", lost_o, 1);
      check_val("loss_e3_locked", locked_o, 0);
`ifdef PLL_CFG_CTRL_RELOCK_EN
      check_val("loss_e3_busy", busy_o, 1);
      check_val("loss_e3_arst", pll_arst_no, 0);
`else
      check_val("loss_e3_busy", busy_o, 0);
      check_val("loss_e3_ready", req_ready_o, 1);
`endif
      // never locks: timeout (request also clears lost)
      start_seq(1'b0, 4'd8, 8'd16, 1000, 1'b0);
      wait_idle(200);
      check_val("timeout_err", err_o, 1);
      // next request clears err; reset mid WAIT_LOCK restarts with defaults
      start_seq(1'b0, 4'd3, 8'd3, 1000, 1'b0);
      repeat (10 - RST_CYCLES) @(negedge clk);
      check_val("midwait_busy", busy_o, 1);
      check_val("midwait_refdiv", refdiv_o, 4'd3);
      start_seq(1'b1, 4'd1, 8'd2, 0, 1'b0);
      wait_idle(100);
      repeat (2) @(negedge clk);
      check_val("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
